// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI byte ranges, receiver/parser state types and bit-period helper
package midi_pkg;
  localparam logic [7:0] STATUS_MIN = 8'h80;
  localparam logic [7:0] SYSCOM_MIN = 8'hF0;
  localparam logic [7:0] RT_MIN = 8'hF8;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DATA1, P_DATA2} p_state_t;
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: synchronised 8N1 byte receiver with mid-bit sampling and framing check
module midi_uart_rx import midi_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 31250
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int BIT = bit_cycles(CLK_HZ, BAUD);
  localparam int CW = $clog2(BIT);
  logic s1, s2, prev;
  rx_state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] sh, sh_nx;
  logic bv_nx, fe_nx, half_done, bit_done;
  assign half_done = cnt == CW'(BIT / 2 - 1);
  assign bit_done = cnt == CW'(BIT - 1);
  assign byte_data = sh;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + CW'(1);
    idx_nx = idx;
    sh_nx = sh;
    bv_nx = 1'b0;
    fe_nx = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nx = '0;
        if (prev && !s2) state_nx = RX_START;
      end
      RX_START: if (half_done) begin
        cnt_nx = '0;
        idx_nx = 3'd0;
        state_nx = s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (bit_done) begin
        cnt_nx = '0;
        sh_nx = {s2, sh[7:1]};
        idx_nx = idx + 3'd1;
        if (idx == 3'd7) state_nx = RX_STOP;
      end
      RX_STOP: if (bit_done) begin
        cnt_nx = '0;
        bv_nx = s2;
        fe_nx = !s2;
        state_nx = RX_IDLE;
      end
      default: state_nx = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
      state <= RX_IDLE;
      cnt <= '0;
      idx <= 3'd0;
      sh <= 8'd0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      prev <= s2;
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      sh <= sh_nx;
      byte_valid <= bv_nx;
      frame_err <= fe_nx;
    end
endmodule

// File: rtl/midi_rx.sv
// midi_rx: MIDI receiver with running-status channel-message parser and real-time byte pass-through
module midi_rx import midi_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 31250
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       midi_ser_rxd,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic       frame_err
);
  logic bv, is_rt, one_data, emit;
  logic [7:0] b, rs, rs_nx, st;
  logic [6:0] d1, d1_nx, e_d1, e_d2;
  p_state_t ps, ps_nx;
  midi_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk(clk),
    .resetb(resetb),
    .rxd(midi_ser_rxd),
    .byte_valid(bv),
    .byte_data(b),
    .frame_err(frame_err)
  );
  assign is_rt = bv && b >= RT_MIN;
  assign one_data = rs[7:4] == 4'hC || rs[7:4] == 4'hD;
  // note-on with zero velocity is reported as the matching note-off
  assign st = (rs[7:4] == 4'h9 && e_d2 == 7'd0) ? {4'h8, rs[3:0]} : rs;
  always_comb begin
    ps_nx = ps;
    rs_nx = rs;
    d1_nx = d1;
    emit = 1'b0;
    e_d1 = d1;
    e_d2 = 7'd0;
    if (bv && !is_rt) begin
      if (b >= SYSCOM_MIN) begin
        rs_nx = 8'd0;
        ps_nx = P_IDLE;
      end else if (b >= STATUS_MIN) begin
        rs_nx = b;
        ps_nx = P_DATA1;
      end else if (ps == P_DATA1 && one_data) begin
        emit = 1'b1;
        e_d1 = b[6:0];
      end else if (ps == P_DATA1) begin
        d1_nx = b[6:0];
        ps_nx = P_DATA2;
      end else if (ps == P_DATA2) begin
        emit = 1'b1;
        e_d2 = b[6:0];
        ps_nx = P_DATA1;
      end
    end
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      ps <= P_IDLE;
      rs <= 8'd0;
      d1 <= 7'd0;
      msg_valid <= 1'b0;
      msg_status <= 8'd0;
      msg_data1 <= 7'd0;
      msg_data2 <= 7'd0;
      rt_valid <= 1'b0;
      rt_byte <= 8'd0;
    end else begin
      ps <= ps_nx;
      rs <= rs_nx;
      d1 <= d1_nx;
      msg_valid <= emit;
      rt_valid <= is_rt;
      if (emit) begin
        msg_status <= st;
        msg_data1 <= e_d1;
        msg_data2 <= e_d2;
      end
      if (is_rt) rt_byte <= b;
    end
endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx: table-driven, directed and random checks of midi_rx against a message-level model
module tb_midi_rx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD = 31250;
  localparam int BIT = CLK_HZ / BAUD;
  localparam int HALF = BIT / 2;
  logic clk = 1'b0, resetb = 1'b0, rxd = 1'b1;
  logic msg_valid, rt_valid, frame_err;
  logic [7:0] msg_status, rt_byte;
  logic [6:0] msg_data1, msg_data2;
  midi_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .resetb(resetb), .midi_ser_rxd(rxd),
    .msg_valid(msg_valid), .msg_status(msg_status), .msg_data1(msg_data1), .msg_data2(msg_data2),
    .rt_valid(rt_valid), .rt_byte(rt_byte), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0, last_start = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [21:0] got_msg[$];
  int got_cyc[$];
  logic [7:0] got_rt[$];
  int n_ferr = 0, hold_bad = 0;
  logic [21:0] last_msg = '0;
  logic [7:0] last_rt = '0;
  always @(negedge clk)
    if (!resetb) begin
      last_msg <= '0;
      last_rt <= '0;
    end else begin
      if (msg_valid) begin
        got_msg.push_back({msg_status, msg_data1, msg_data2});
        got_cyc.push_back(cyc);
        last_msg <= {msg_status, msg_data1, msg_data2};
      end else if ({msg_status, msg_data1, msg_data2} != last_msg) hold_bad <= hold_bad + 1;
      if (rt_valid) begin
        got_rt.push_back(rt_byte);
        last_rt <= rt_byte;
      end else if (rt_byte != last_rt) hold_bad <= hold_bad + 1;
      if (frame_err) n_ferr <= n_ferr + 1;
    end
  // reference model: running status plus a queue of collected data bytes
  logic [7:0] m_rs = '0;
  logic [6:0] m_data[$];
  logic [21:0] exp_msg[$];
  logic [7:0] exp_rt[$];
  int exp_ferr = 0, mi = 0, ri = 0;
  task automatic model(input logic [7:0] b);
    logic [7:0] st;
    logic [6:0] d2;
    if (b >= 8'hF8) exp_rt.push_back(b);
    else if (b >= 8'hF0) begin m_rs = 8'd0; m_data.delete(); end
    else if (b >= 8'h80) begin m_rs = b; m_data.delete(); end
    else if (m_rs != 8'd0) begin
      m_data.push_back(b[6:0]);
      if (m_data.size() == ((m_rs[7:4] == 4'hC || m_rs[7:4] == 4'hD) ? 1 : 2)) begin
        st = m_rs;
        d2 = (m_data.size() == 2) ? m_data[1] : 7'd0;
        if (st[7:4] == 4'h9 && d2 == 7'd0) st[4] = 1'b0;
        exp_msg.push_back({st, m_data[0], d2});
        m_data.delete();
      end
    end
  endtask
  task automatic model_reset();
    m_rs = 8'd0;
    m_data.delete();
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_start = cyc;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk);
    rxd = 1'b1;
  endtask
  task automatic tx(input logic [7:0] b);
    send_byte(b, 1'b1);
    model(b);
  endtask
  task automatic do_reset();
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask
  task automatic compare_all(input string tag);
    repeat (8) @(negedge clk);
    chk({tag, " msg count"}, 32'(got_msg.size()), 32'(exp_msg.size()));
    chk({tag, " rt count"}, 32'(got_rt.size()), 32'(exp_rt.size()));
    chk({tag, " ferr count"}, 32'(n_ferr), 32'(exp_ferr));
    while (mi < got_msg.size() && mi < exp_msg.size()) begin
      chk($sformatf("%s msg#%0d", tag, mi), 32'(got_msg[mi]), 32'(exp_msg[mi]));
      mi++;
    end
    while (ri < got_rt.size() && ri < exp_rt.size()) begin
      chk($sformatf("%s rt#%0d", tag, ri), 32'(got_rt[ri]), 32'(exp_rt[ri]));
      ri++;
    end
  endtask
  typedef struct {
    logic [39:0] bytes;
    int n;
    int n_msg;
    logic [21:0] last;
    int n_rt;
  } vec_t;
  vec_t vt[8];
  int bm, br, bf, lat;
  logic [7:0] rb;
  initial begin
    vt[0] = '{40'h903C640000, 3, 1, {8'h90, 7'h3C, 7'h64}, 0};
    vt[1] = '{40'h9140504100, 5, 2, {8'h81, 7'h41, 7'h00}, 0};
    vt[2] = '{40'hC205060000, 3, 2, {8'hC2, 7'h06, 7'h00}, 0};
    vt[3] = '{40'hB007F87F00, 4, 1, {8'hB0, 7'h07, 7'h7F}, 1};
    vt[4] = '{40'h1020903000, 5, 1, {8'h80, 7'h30, 7'h00}, 0};
    vt[5] = '{40'h903CF64050, 5, 0, 22'd0, 0};
    vt[6] = '{40'hD37F010000, 3, 2, {8'hD3, 7'h01, 7'h00}, 0};
    vt[7] = '{40'hE00040FF00, 4, 1, {8'hE0, 7'h00, 7'h40}, 1};
    repeat (2) @(negedge clk);
    chk("reset msg outs", {8'd0, msg_valid, msg_status, msg_data1, msg_data2}, 32'd0);
    chk("reset rt outs", {rt_valid, rt_byte, frame_err}, 32'd0);
    for (int v = 0; v < 8; v++) begin
      do_reset();
      bm = got_msg.size();
      br = got_rt.size();
      for (int i = 0; i < vt[v].n; i++) tx(vt[v].bytes[39 - 8 * i -: 8]);
      repeat (8) @(negedge clk);
      chk($sformatf("vec%0d msgs", v), 32'(got_msg.size() - bm), 32'(vt[v].n_msg));
      chk($sformatf("vec%0d last", v), 32'({msg_status, msg_data1, msg_data2}), 32'(vt[v].last));
      chk($sformatf("vec%0d rts", v), 32'(got_rt.size() - br), 32'(vt[v].n_rt));
      if (v == 0 && got_msg.size() > bm) begin
        lat = got_cyc[bm] - last_start;
        tests++;
        if (lat < HALF + 9 * BIT + 3 || lat > HALF + 9 * BIT + 5) begin
          fails++;
          $display("FAIL msg latency: got %0d cycles, expected %0d..%0d", lat, HALF + 9 * BIT + 3, HALF + 9 * BIT + 5);
        end
      end
      compare_all($sformatf("vec%0d", v));
    end
    // running status over program change, real-time interleave, then completion by a lone data byte
    do_reset();
    bm = got_msg.size();
    foreach (vt[0].bytes[i]) ;
    tx(8'hC2); tx(8'h05); tx(8'h06); tx(8'h90); tx(8'h3C); tx(8'hF8); tx(8'h7F);
    repeat (8) @(negedge clk);
    chk("seq39 msgs", 32'(got_msg.size() - bm), 32'd3);
    chk("seq39 last", 32'({msg_status, msg_data1, msg_data2}), 32'({8'h90, 7'h3C, 7'h7F}));
    chk("seq39 rt_byte", 32'(rt_byte), 32'h0F8);
    compare_all("seq39");
    // framing error in the middle of a message discards the byte
    bm = got_msg.size();
    bf = n_ferr;
    tx(8'h90); tx(8'h3C);
    send_byte(8'h40, 1'b0);
    exp_ferr++;
    repeat (8) @(negedge clk);
    chk("ferr pulses", 32'(n_ferr - bf), 32'd1);
    chk("ferr no msg", 32'(got_msg.size() - bm), 32'd0);
    tx(8'h80); tx(8'h3C); tx(8'h00);
    repeat (8) @(negedge clk);
    chk("after ferr last", 32'({msg_status, msg_data1, msg_data2}), 32'({8'h80, 7'h3C, 7'h00}));
    compare_all("ferr");
    // short low glitch on idle line, then sysex clears running status
    tx(8'h90); tx(8'h3C); tx(8'h40);
    repeat (8) @(negedge clk);
    bm = got_msg.size();
    bf = n_ferr;
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk);
    tx(8'hF0); tx(8'h01); tx(8'h7F); tx(8'hF7); tx(8'h11); tx(8'h22);
    repeat (8) @(negedge clk);
    chk("glitch no msg", 32'(got_msg.size() - bm), 32'd0);
    chk("glitch no ferr", 32'(n_ferr - bf), 32'd0);
    chk("sysex rs", 32'(dut.rs), 32'd0);
    compare_all("glitch");
    // reset during bit 4 of a byte
    tx(8'h90); tx(8'h3C); tx(8'h64); tx(8'hF9);
    fork
      send_byte(8'h90, 1'b1);
      begin
        repeat (HALF + 4 * BIT + 3) @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
        chk("midreset msg outs", {8'd0, msg_valid, msg_status, msg_data1, msg_data2}, 32'd0);
        chk("midreset rt outs", {rt_valid, rt_byte, frame_err}, 32'd0);
      end
    join
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    bm = got_msg.size();
    tx(8'h90); tx(8'h3C); tx(8'h64);
    repeat (8) @(negedge clk);
    chk("postreset msgs", 32'(got_msg.size() - bm), 32'd1);
    chk("postreset last", 32'({msg_status, msg_data1, msg_data2}), 32'({8'h90, 7'h3C, 7'h64}));
    compare_all("reset");
    // random byte stream
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5: rb = 8'($urandom_range(8'h80, 8'hEF));
        6: rb = 8'($urandom_range(8'hF0, 8'hF7));
        7, 8: rb = 8'($urandom_range(8'hF8, 8'hFF));
        9: rb = 8'h00;
        default: rb = 8'($urandom_range(0, 8'h7F));
      endcase
      tx(rb);
    end
    compare_all("random");
    chk("hold violations", 32'(hold_bad), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/midi_rx.md
MIDI_RX -- requirements
Module: midi_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 31250, MIDI serial bit rate.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 resetb  input  1  asynchronous, active-low reset.
REQ-005 midi_ser_rxd  input  1  asynchronous MIDI serial line, idle high.
REQ-006 msg_valid  output  1  one-cycle pulse: complete channel message on msg_* outputs.
REQ-007 msg_status  output  8  status byte of the message, 0x80-0xEF.
REQ-008 msg_data1  output  7  first data byte.
REQ-009 msg_data2  output  7  second data byte; 0 for one-data-byte messages.
REQ-010 rt_valid  output  1  one-cycle pulse: system real-time byte received.
REQ-011 rt_byte  output  8  received real-time byte, 0xF8-0xFF.
REQ-012 frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-013 midi_ser_rxd SHALL pass through a 2-flop synchronizer before any use.
- Byte receiver
REQ-014 Bit period SHALL be BIT = CLK_HZ/BAUD cycles (1600 at defaults), integer division.
REQ-015 States SHALL be RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-016 RX_IDLE -> RX_START on synchronized line high-to-low.
REQ-017 RX_START SHALL wait BIT/2 cycles, then resample: low -> RX_DATA, high -> RX_IDLE with no output (glitch).
REQ-018 RX_DATA SHALL sample 8 bits, LSB first, every BIT cycles from the start-bit centre.
REQ-019 RX_STOP SHALL sample BIT cycles after bit 7: high -> byte accepted; low -> frame_err pulse, byte discarded.
REQ-020 After RX_STOP the receiver SHALL return to RX_IDLE and be able to detect a new start edge on the next cycle.
REQ-021 An accepted byte SHALL reach the parser exactly 1 cycle after the stop-bit sample.
- Message parser
REQ-022 The parser SHALL hold running status rs (8 bits, 0 = none) and states P_IDLE, P_DATA1, P_DATA2.
REQ-023 Byte 0x80-0xEF in any state: rs <= byte, drop any partial message, go to P_DATA1.
REQ-024 Byte 0xF0-0xF7 in any state: rs <= 0, drop any partial message, go to P_IDLE.
REQ-025 Byte 0xF8-0xFF: rt_byte <= byte, pulse rt_valid; rs, state, and partial data unchanged.
REQ-026 Data byte (<0x80) in P_IDLE SHALL be ignored.
REQ-027 Data byte in P_DATA1 with rs[7:4] = 0xC or 0xD SHALL emit the message with data2 = 0 and stay in P_DATA1.
REQ-028 Other data byte in P_DATA1: store as data1, go to P_DATA2.
REQ-029 Data byte in P_DATA2: emit the message and return to P_DATA1, so running status applies.
REQ-030 Note-on (0x9n) with data2 = 0 SHALL be emitted as msg_status 0x8n, data1 unchanged, data2 = 0.
REQ-031 msg_valid SHALL pulse exactly 1 cycle after the parser receives the completing byte, i.e. 2 cycles after its stop-bit sample.
REQ-032 msg_status, msg_data1, msg_data2 and rt_byte SHALL hold their values until the next respective pulse.

Reset
REQ-033 resetb low SHALL asynchronously force:
- receiver to RX_IDLE and parser to P_IDLE;
- rs to 0;
- all pulse outputs to 0;
- msg_status, msg_data1, msg_data2 and rt_byte to 0;
- synchronizer flops to 1.
REQ-034 Reset asserted mid-byte SHALL discard that byte. After release, the next valid start edge SHALL be received normally.

Structure
REQ-035 Package midi_pkg SHALL hold the status range constants, the rx and parser state enums, and the function computing BIT from CLK_HZ and BAUD.
REQ-036 The byte receiver SHALL be sub-module midi_uart_rx, with outputs byte_valid, byte_data and frame_err. The parser SHALL reside in midi_rx.

Verification
REQ-037 Send 0x90 0x3C 0x64 -> one msg_valid with 0x90/0x3C/0x64, 2 cycles after the last stop-bit sample.
REQ-038 Send 0x91 0x40 0x50 0x41 0x00 -> two pulses: 0x91/0x40/0x50, then 0x81/0x41/0x00 (running status plus velocity-0 conversion).
REQ-039 Send 0xC2 0x05 0x06, then 0x90 0x3C, then 0xF8, then 0x7F:
- 0xC2 0x05 0x06 -> pulses 0xC2/0x05/0 and 0xC2/0x06/0;
- the F8 -> rt_valid with rt_byte 0xF8;
- the trailing 0x7F -> 0x90/0x3C/0x7F.
REQ-040 Send a byte with stop bit low -> frame_err pulse, no msg_valid; a following valid 0x80 0x3C 0x00 is received normally.
REQ-041 Apply a 500-cycle low glitch on an idle line, then 0xF0 0x01 0x7F 0xF7 -> no msg_valid, no frame_err, rs = 0.
REQ-042 Assert resetb during bit 4 of 0x90, release, then send 0x90 0x3C 0x64 -> outputs 0 during reset, then exactly one message 0x90/0x3C/0x64.
